de2_pio_hex_ctrl: RTL and testbench

DE2_PIO_HEX_CTRL -- requirements
Module: de2_pio_hex_ctrl

---
 rtl/de2_pio_pkg.sv | 32 +++
 rtl/de2_pio_blink_timer.sv | 51 +++++
 rtl/de2_pio_hex_ctrl.sv | 102 ++++++++++
 tb/tb_de2_pio_hex_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/de2_pio_pkg.sv
// Shared register map, control-bit layout and segment constants for the
// DE2 PIO seven-segment controller.
package de2_pio_pkg;

  // Avalon-MM word offsets
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_CTRL     = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  // CTRL register layout
  localparam int CTRL_W         = 2;
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_BLANK_BIT = 1;

  // Other register / bus widths
  localparam int STATUS_W = 1;
  localparam int BUS_W    = 32;
  localparam int SEG_W    = 7;

  // Active-low segments: all ones turns every segment off
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Select the drive pattern for one digit
  function automatic logic [SEG_W-1:0] seg_value(input logic [SEG_W-1:0] digit,
                                                 input logic             blank);
    return blank ? SEG_BLANK : digit;
  endfunction

endpackage

// File: rtl/de2_pio_blink_timer.sv
// Blink half-period counter and phase flag. Runs only while en=1; clr
// returns both counter and phase to zero.
module de2_pio_blink_timer #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic phase
);

  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  // Next-state: count up, wrap on the last cycle and flip phase on that edge
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/de2_pio_hex_ctrl.sv
// Avalon-MM slave driving DIGITS active-low seven-segment displays with
// per-digit blink, global blank and atomic set/clear of the data register.
module de2_pio_hex_ctrl
  import de2_pio_pkg::*;
#(
  parameter int DATA_WIDTH = 28,
  parameter int DIGITS     = DATA_WIDTH / 7,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [BUS_W-1:0]      writedata,
  output logic [BUS_W-1:0]      readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DIGITS-1:0]     mask_q, mask_d;
  logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  wr_en;
  logic                  timer_clr;
  logic                  phase;
  logic                  unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  // Writing CTRL with EN=0 restarts the blink period from zero
  assign timer_clr = wr_en && (address == ADDR_CTRL) && !writedata[CTRL_EN_BIT];

  de2_pio_blink_timer #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (ctrl_q[CTRL_EN_BIT]),
    .clr     (timer_clr),
    .phase   (phase)
  );

  // Register write decode; upper writedata bits are simply not sampled
  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    ctrl_d = ctrl_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_d = writedata[DATA_WIDTH-1:0];
        ADDR_MASK:     mask_d = writedata[DIGITS-1:0];
        ADDR_CTRL:     ctrl_d = writedata[CTRL_W-1:0];
        ADDR_OUTSET:   data_d = data_q | writedata[DATA_WIDTH-1:0];
        ADDR_OUTCLEAR: data_d = data_q & ~writedata[DATA_WIDTH-1:0];
        default:       ;
      endcase
    end
  end

  // Per-digit segment pattern from the current register state
  always_comb begin
    out_d = '0;
    for (int d = 0; d < DIGITS; d++) begin
      out_d[d*SEG_W +: SEG_W] = seg_value(
        data_q[d*SEG_W +: SEG_W],
        ctrl_q[CTRL_BLANK_BIT] | (ctrl_q[CTRL_EN_BIT] & phase & mask_q[d]));
    end
  end

  // Register file and output stage
  always_ff @(posedge clk) begin
    // NOTE: reset wins over a concurrent bus write because it is tested first.
    if (!reset_n) begin
      data_q <= '0;
      mask_q <= '0;
      ctrl_q <= '0;
      out_q  <= '0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      ctrl_q <= ctrl_d;
      out_q  <= out_d;
    end
  end

  // Combinational read mux, independent of chipselect
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[DATA_WIDTH-1:0] = data_q;
      ADDR_MASK:   readdata[DIGITS-1:0]     = mask_q;
      ADDR_CTRL:   readdata[CTRL_W-1:0]     = ctrl_q;
      ADDR_STATUS: readdata[STATUS_W-1:0]   = phase;
      default:     readdata = '0;
    endcase
  end

  assign out_port = out_q;

endmodule

// File: tb/tb_de2_pio_hex_ctrl.sv
// Directed bench for de2_pio_hex_ctrl with a short blink period.
module tb_de2_pio_hex_ctrl;

  localparam int DATA_WIDTH = 28;
  localparam int BLINK_DIV  = 4;

  logic                  clk;
  logic                  reset_n;
  logic [2:0]            address;
  logic                  chipselect;
  logic                  write_n;
  logic [31:0]           writedata;
  logic [31:0]           readdata;
  logic [DATA_WIDTH-1:0] out_port;

  int checks;
  int errors;

  de2_pio_hex_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .BLINK_DIV  (BLINK_DIV)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the write edge
  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string tag);
    address = addr;
    #1;
    check(tag, readdata, exp);
  endtask

  initial begin
    logic [31:0] exp_out;
    logic        exp_phase;
    checks     = 0;
    errors     = 0;
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    @(negedge clk);

    // Reset overrides a concurrent write
    wr(3'd0, 32'h1234567);
    rd(3'd0, 32'h0, "rst_data");
    rd(3'd1, 32'h0, "rst_mask");
    rd(3'd2, 32'h0, "rst_ctrl");
    rd(3'd3, 32'h0, "rst_status");
    check("rst_out", 32'(out_port), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Set / clear
    wr(3'd0, 32'h00000F0);
    wr(3'd4, 32'h000000F);
    wr(3'd5, 32'h0000030);
    rd(3'd0, 32'h00000CF, "setclr_data");
    check("setclr_out_lag", 32'(out_port), 32'h00000FF);
    @(negedge clk);
    check("setclr_out", 32'(out_port), 32'h00000CF);

    // Writes to read-only / unmapped offsets are ignored; wide writes truncate
    wr(3'd3, 32'hFFFFFFFF);
    wr(3'd6, 32'hFFFFFFFF);
    wr(3'd7, 32'hFFFFFFFF);
    rd(3'd3, 32'h0, "ro_status");
    rd(3'd0, 32'h00000CF, "ignored_wr_data");
    wr(3'd1, 32'hFFFFFFF0);
    rd(3'd1, 32'h0, "mask_width");
    wr(3'd2, 32'hFFFFFFFC);
    rd(3'd2, 32'h0, "ctrl_width");

    // Blink digit 0: phase after edge k is (k/4)%2, out_port lags one edge
    wr(3'd0, 32'h0);
    wr(3'd1, 32'h1);
    wr(3'd2, 32'h1);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      exp_phase = ((k / 4) % 2) == 1;
      exp_out   = (((k - 1) / 4) % 2 == 1) ? 32'h7F : 32'h0;
      rd(3'd3, {31'd0, exp_phase}, $sformatf("blink_status_k%0d", k));
      check($sformatf("blink_out_k%0d", k), 32'(out_port), exp_out);
    end

    // Disable during phase=1
    wr(3'd2, 32'h0);
    rd(3'd3, 32'h0, "dis_status");
    check("dis_out_lag", 32'(out_port), 32'h7F);
    @(negedge clk);
    check("dis_out", 32'(out_port), 32'h0);
    rd(3'd3, 32'h0, "dis_status_hold");

    // Blank all
    wr(3'd0, 32'h1234567);
    wr(3'd2, 32'h2);
    check("blank_out_lag", 32'(out_port), 32'h1234567);
    @(negedge clk);
    check("blank_out", 32'(out_port), 32'hFFFFFFF);
    rd(3'd0, 32'h1234567, "blank_data");
    rd(3'd2, 32'h2, "blank_ctrl");
    for (int a = 4; a <= 7; a++) begin
      rd(3'(a), 32'h0, $sformatf("rd_off%0d", a));
    end

    // Reset mid-blink discards counter state
    wr(3'd2, 32'h1);
    for (int k = 0; k < 5; k++) @(negedge clk);
    rd(3'd3, 32'h1, "pre_rst_phase");
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rd(3'd3, 32'h0, "mid_rst_status");
    rd(3'd0, 32'h0, "mid_rst_data");
    rd(3'd2, 32'h0, "mid_rst_ctrl");
    check("mid_rst_out", 32'(out_port), 32'h0);
    for (int k = 0; k < 6; k++) @(negedge clk);
    rd(3'd3, 32'h0, "post_rst_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
